// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a per-grant hold limit.
// Grant, index, valid and timeout are all driven straight from flops.
module rr_arbiter4 #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [1:0]       last_ptr_q;
    logic [3:0]       grant_q;
    logic [1:0]       grant_idx_q;
    logic             grant_valid_q;
    logic             timeout_q;

    logic [1:0]       win_idx_c;
    logic             win_found_c;
    logic [1:0]       cand_c;
    logic             release_c;

    // Scan from the client after the last owner; first active request wins.
    always_comb begin
        win_idx_c   = 2'd0;
        win_found_c = 1'b0;
        cand_c      = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand_c = last_ptr_q + 2'(k);
            if (!win_found_c && req[cand_c]) begin
                win_idx_c   = cand_c;
                win_found_c = 1'b1;
            end
        end
    end

    // Owner gave the resource back voluntarily (done or request withdrawn).
    assign release_c = done || !req[grant_idx_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            hold_cnt_q    <= '0;
            last_ptr_q    <= 2'd3;
            grant_q       <= 4'b0000;
            grant_idx_q   <= 2'd0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    timeout_q <= 1'b0;
                    if (win_found_c) begin
                        grant_q       <= 4'b0001 << win_idx_c;
                        grant_idx_q   <= win_idx_c;
                        grant_valid_q <= 1'b1;
                        hold_cnt_q    <= '0;
                        state_q       <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (release_c || (hold_cnt_q == HOLD_LAST)) begin
                        // Forced release only flags timeout when the owner had not let go.
                        timeout_q     <= !release_c;
                        last_ptr_q    <= grant_idx_q;
                        grant_q       <= 4'b0000;
                        grant_idx_q   <= 2'd0;
                        grant_valid_q <= 1'b0;
                        hold_cnt_q    <= '0;
                        state_q       <= S_IDLE;
                    end else begin
                        timeout_q  <= 1'b0;
                        hold_cnt_q <= hold_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q       <= S_IDLE;
                    grant_q       <= 4'b0000;
                    grant_idx_q   <= 2'd0;
                    grant_valid_q <= 1'b0;
                    timeout_q     <= 1'b0;
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: hand-computed grant sequences plus per-cycle invariants.
module tb_rr_arbiter4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    rr_arbiter4 #(.MAX_HOLD(8), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .done       (done),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] idx,
                             input logic v, input logic to);
        check_eq({tag, ".grant"}, grant, g);
        check_eq({tag, ".idx"}, {2'b00, grant_idx}, {2'b00, idx});
        check_eq({tag, ".valid"}, {3'b000, grant_valid}, {3'b000, v});
        check_eq({tag, ".timeout"}, {3'b000, timeout}, {3'b000, to});
    endtask

    // Structural invariants, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check_eq("inv_onehot", {3'b000, ((grant & (grant - 4'd1)) == 4'd0)}, 4'd1);
            check_eq("inv_valid", {3'b000, grant_valid}, {3'b000, |grant});
            check_eq("inv_idx", grant, grant_valid ? (4'b0001 << grant_idx) : 4'b0000);
            check_eq("inv_idx0", {2'b00, grant_idx}, 4'd0 & {4{~grant_valid}} | {2'b00, grant_idx} & {4{grant_valid}});
            check_eq("inv_to", {3'b000, timeout & grant_valid}, 4'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    logic [3:0] seq_g [5];
    logic [1:0] seq_i [5];

    initial begin
        // Reset state
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        #2;
        check_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        do_reset();
        check_out("reset_rel", 4'b0000, 2'd0, 1'b0, 1'b0);

        // 1: single requester, done on third grant cycle
        req = 4'b0001;
        tick();
        check_out("t1_c1", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        check_out("t1_c2", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        check_out("t1_c3", 4'b0001, 2'd0, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        done = 1'b0;
        check_out("t1_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        check_out("t1_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);

        // 2: all request, each owner done immediately
        do_reset();
        seq_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        seq_i = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        req  = 4'b1111;
        done = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick();
            check_out($sformatf("t2_g%0d", n), seq_g[n], seq_i[n], 1'b1, 1'b0);
            tick();
            check_out($sformatf("t2_i%0d", n), 4'b0000, 2'd0, 1'b0, 1'b0);
        end

        // 3: forced release after MAX_HOLD cycles
        do_reset();
        req = 4'b0100;
        for (int n = 0; n < 8; n++) begin
            tick();
            check_out($sformatf("t3_hold%0d", n), 4'b0100, 2'd2, 1'b1, 1'b0);
        end
        tick();
        check_out("t3_timeout", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick();
        check_out("t3_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);

        // 4: done and req drop together, pointer moves past client 1
        do_reset();
        req = 4'b0010;
        tick();
        check_out("t4_own1", 4'b0010, 2'd1, 1'b1, 1'b0);
        req  = 4'b1001;
        done = 1'b1;
        tick();
        check_out("t4_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
        req  = 4'b1011;
        done = 1'b0;
        tick();
        check_out("t4_next", 4'b1000, 2'd3, 1'b1, 1'b0);

        // 5: asynchronous reset mid-grant
        do_reset();
        req = 4'b0010;
        tick();
        repeat (4) tick();
        check_out("t5_pre", 4'b0010, 2'd1, 1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check_out("t5_async", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b1010;
        #2;
        rst_n = 1'b1;
        tick();
        check_out("t5_first", 4'b0010, 2'd1, 1'b1, 1'b0);

        // 6: done toggling with no requests
        do_reset();
        for (int n = 0; n < 10; n++) begin
            done = ~done;
            tick();
            check_out($sformatf("t6_%0d", n), 4'b0000, 2'd0, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
